// File: rtl/data_memory_access_unit_if.sv
// -----------------------------------------------------------------------------
// data_memory_access_unit_if
// Bundles the pipeline request/response handshake and the data-memory pins of
// the MEM-stage access unit.
//   Request  : ReqValid, ReqReady, ReqWrite, ReqSize, ReqSigned, ReqAddress,
//              ReqWriteData
//   Response : RespValid, RespData, MisalignedError, Stall
//   Memory   : MemAddress, MemWriteData, MemRead, MemWrite, MemReadData
// Modports:
//   slave  - the access unit (consumes requests, drives the memory pins)
//   master - the pipeline / memory environment around it
// -----------------------------------------------------------------------------
interface data_memory_access_unit_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 6
);
    logic                     ReqValid;
    logic                     ReqReady;
    logic                     ReqWrite;
    logic [1:0]               ReqSize;
    logic                     ReqSigned;
    logic [ADDRESS_WIDTH+1:0] ReqAddress;
    logic [DATA_WIDTH-1:0]    ReqWriteData;
    logic                     RespValid;
    logic [DATA_WIDTH-1:0]    RespData;
    logic                     MisalignedError;
    logic                     Stall;
    logic [ADDRESS_WIDTH-1:0] MemAddress;
    logic [DATA_WIDTH-1:0]    MemWriteData;
    logic                     MemRead;
    logic                     MemWrite;
    logic [DATA_WIDTH-1:0]    MemReadData;

    modport slave (
        input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddress, ReqWriteData,
        input  MemReadData,
        output ReqReady, RespValid, RespData, MisalignedError, Stall,
        output MemAddress, MemWriteData, MemRead, MemWrite
    );

    modport master (
        output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddress, ReqWriteData,
        output MemReadData,
        input  ReqReady, RespValid, RespData, MisalignedError, Stall,
        input  MemAddress, MemWriteData, MemRead, MemWrite
    );
endinterface

// File: rtl/data_memory_access_unit.sv
// -----------------------------------------------------------------------------
// data_memory_access_unit
// MEM-stage initiator for a word-organised data memory. Accepts load/store
// requests, checks alignment, performs word stores directly, sub-word stores by
// read-modify-write, and returns sign/zero-extended load data.
// Ports:
//   Clock  - single clock, all state on posedge
//   Reset  - synchronous, active-high
//   bus    - data_memory_access_unit_if.slave (request, response, memory pins)
// Memory contract: MemRead in cycle N -> MemReadData valid in cycle N+1;
// MemWrite commits at the negedge of the cycle it is high.
// -----------------------------------------------------------------------------
module data_memory_access_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 6
) (
    input  logic                           Clock,
    input  logic                           Reset,
    data_memory_access_unit_if.slave       bus
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ERR       = 4'd1,
        S_WRITE     = 4'd2,
        S_READ      = 4'd3,
        S_CAPTURE   = 4'd4,
        S_RESP      = 4'd5,
        S_RMW_READ  = 4'd6,
        S_RMW_MERGE = 4'd7,
        S_RMW_WRITE = 4'd8
    } state_e;

    state_e                   state_q, state_d;
    logic [1:0]               size_q, size_d;
    logic                     signed_q, signed_d;
    logic [1:0]               offset_q, offset_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]    resp_data_q, resp_data_d;
    logic                     mis_err_q, mis_err_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic                     mem_read_q, mem_read_d;
    logic                     mem_write_q, mem_write_d;

    // Size 11 is never legal; halves need an even address, words a multiple of 4.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic r;
        case (size)
            2'b00:   r = 1'b0;
            2'b01:   r = off[0];
            2'b10:   r = (off != 2'b00);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    // Pull the addressed little-endian lane out of a word and extend it.
    function automatic logic [DATA_WIDTH-1:0] extract_lane(
        input logic [DATA_WIDTH-1:0] word, input logic [1:0] size,
        input logic sgn, input logic [1:0] off);
        logic [DATA_WIDTH-1:0] sh;
        logic [DATA_WIDTH-1:0] r;
        sh = word >> {off, 3'b000};
        case (size)
            2'b00:   r = {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   r = {{16{sgn & sh[15]}}, sh[15:0]};
            2'b10:   r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Replace only the addressed lane; every other bit of the old word survives.
    function automatic logic [DATA_WIDTH-1:0] merge_lane(
        input logic [DATA_WIDTH-1:0] word, input logic [DATA_WIDTH-1:0] wdata,
        input logic [1:0] size, input logic [1:0] off);
        logic [DATA_WIDTH-1:0] mask;
        logic [DATA_WIDTH-1:0] ins;
        case (size)
            2'b00: begin
                mask = 32'h0000_00FF << {off, 3'b000};
                ins  = {24'h00_0000, wdata[7:0]} << {off, 3'b000};
            end
            2'b01: begin
                mask = 32'h0000_FFFF << {off, 3'b000};
                ins  = {16'h0000, wdata[15:0]} << {off, 3'b000};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                ins  = wdata;
            end
        endcase
        return (word & ~mask) | (ins & mask);
    endfunction

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        signed_d     = signed_q;
        offset_d     = offset_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_data_d  = 32'h0000_0000;
        mis_err_d    = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.ReqValid) begin
                    size_d   = bus.ReqSize;
                    signed_d = bus.ReqSigned;
                    offset_d = bus.ReqAddress[1:0];
                    wdata_d  = bus.ReqWriteData;
                    if (is_misaligned(bus.ReqSize, bus.ReqAddress[1:0])) begin
                        state_d      = S_ERR;
                        resp_valid_d = 1'b1;
                        mis_err_d    = 1'b1;
                    end else begin
                        mem_addr_d = bus.ReqAddress[ADDRESS_WIDTH+1:2];
                        if (bus.ReqWrite && (bus.ReqSize == 2'b10)) begin
                            state_d      = S_WRITE;
                            mem_write_d  = 1'b1;
                            mem_wdata_d  = bus.ReqWriteData;
                            resp_valid_d = 1'b1;
                        end else if (bus.ReqWrite) begin
                            state_d    = S_RMW_READ;
                            mem_read_d = 1'b1;
                        end else begin
                            state_d    = S_READ;
                            mem_read_d = 1'b1;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ:      state_d = S_CAPTURE;
            S_CAPTURE: begin
                // MemReadData is valid this cycle (strobe was in READ).
                resp_data_d  = extract_lane(bus.MemReadData, size_q, signed_q, offset_q);
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
            end
            S_RMW_READ:  state_d = S_RMW_MERGE;
            S_RMW_MERGE: begin
                mem_wdata_d  = merge_lane(bus.MemReadData, wdata_q, size_q, offset_q);
                mem_write_d  = 1'b1;
                resp_valid_d = 1'b1;
                state_d      = S_RMW_WRITE;
            end
            S_ERR, S_WRITE, S_RESP, S_RMW_WRITE: state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; Reset aborts any access in flight.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            offset_q     <= 2'b00;
            wdata_q      <= 32'h0000_0000;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'h0000_0000;
            mis_err_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0000_0000;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            offset_q     <= offset_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            mis_err_q    <= mis_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
        end
    end

    assign bus.ReqReady        = (state_q == S_IDLE) && !Reset;
    assign bus.Stall           = bus.ReqValid && !resp_valid_q;
    assign bus.RespValid       = resp_valid_q;
    assign bus.RespData        = resp_data_q;
    assign bus.MisalignedError = mis_err_q;
    assign bus.MemAddress      = mem_addr_q;
    assign bus.MemWriteData    = mem_wdata_q;
    assign bus.MemRead         = mem_read_q;
    assign bus.MemWrite        = mem_write_q;

endmodule

// File: tb/tb_data_memory_access_unit.sv
// -----------------------------------------------------------------------------
// tb_data_memory_access_unit
// Self-checking bench: a behavioural 64-word memory, a response scoreboard,
// a table of single requests, and hand-written reset / held-ReqValid sequences.
// -----------------------------------------------------------------------------
module tb_data_memory_access_unit;

    logic Clock;
    logic Reset;

    data_memory_access_unit_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(6)) bus();

    data_memory_access_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(6)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        pre_en;
        logic [31:0] pre_val;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_mem;
    } vec_t;

    logic [31:0] mem [0:63];
    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          rd_cnt   = 0;
    int          wr_cnt   = 0;
    bit          run      = 0;
    vec_t        vecs[$];

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Memory model: registered read, write committed at negedge.
    always @(posedge Clock) begin
        if (bus.MemRead === 1'b1) bus.MemReadData <= mem[bus.MemAddress];
    end

    always @(negedge Clock) begin
        if (bus.MemWrite === 1'b1) mem[bus.MemAddress] = bus.MemWriteData;
    end

    // Response monitor / scoreboard and strobe counters.
    always @(negedge Clock) begin
        if (run) begin
            if (bus.MemRead === 1'b1) rd_cnt++;
            if (bus.MemWrite === 1'b1) wr_cnt++;
            if (bus.MemRead === 1'b1 || bus.MemWrite === 1'b1)
                check("rw_exclusive", 32'(bus.MemRead & bus.MemWrite), 32'd0);
            if (bus.RespValid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_resp", 32'(bus.RespValid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("resp_data", bus.RespData, e.data);
                    check("resp_err", 32'(bus.MisalignedError), 32'(e.err));
                end
            end
        end
    end

    function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sgn,
                                input logic [7:0] addr, input logic [31:0] wdata,
                                input logic pre_en, input logic [31:0] pre_val,
                                input logic [31:0] exp_data, input logic exp_err,
                                input int exp_lat, input int exp_rd, input int exp_wr,
                                input logic [31:0] exp_mem);
        vec_t v;
        v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.pre_en = pre_en; v.pre_val = pre_val; v.exp_data = exp_data; v.exp_err = exp_err;
        v.exp_lat = exp_lat; v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.exp_mem = exp_mem;
        return v;
    endfunction

    task automatic do_req(input vec_t v, input int idx);
        int  lat;
        int  r0;
        int  w0;
        bit  got;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge Clock);
        if (v.pre_en) mem[v.addr[7:2]] = v.pre_val;
        check({tag, "_ready"}, 32'(bus.ReqReady), 32'd1);
        bus.ReqValid     = 1'b1;
        bus.ReqWrite     = v.wr;
        bus.ReqSize      = v.size;
        bus.ReqSigned    = v.sgn;
        bus.ReqAddress   = v.addr;
        bus.ReqWriteData = v.wdata;
        sb_q.push_back('{v.exp_data, v.exp_err});
        r0 = rd_cnt;
        w0 = wr_cnt;
        @(posedge Clock);
        lat = 0;
        got = 0;
        while (!got && lat < 10) begin
            @(negedge Clock);
            lat++;
            if (lat == 1) bus.ReqValid = 1'b0;
            if (bus.RespValid === 1'b1) got = 1;
        end
        check({tag, "_resp_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        @(negedge Clock);
        check({tag, "_reads"}, 32'(rd_cnt - r0), 32'(v.exp_rd));
        check({tag, "_writes"}, 32'(wr_cnt - w0), 32'(v.exp_wr));
        check({tag, "_mem"}, mem[v.addr[7:2]], v.exp_mem);
    endtask

    initial begin
        int  r0;
        int  w0;
        int  cyc;
        bit  got;
        bit  stall_ok;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
        bus.ReqValid = 1'b0; bus.ReqWrite = 1'b0; bus.ReqSize = 2'b00;
        bus.ReqSigned = 1'b0; bus.ReqAddress = 8'h00; bus.ReqWriteData = 32'h0;

        // Stimulus table: wr size sgn addr wdata | preset | data err lat rd wr mem
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0,        32'h00000000, 1'b0, 1, 0, 1, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 8'h10, 32'h0,        1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1, 0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 8'h12, 32'h123456AB, 1'b1, 32'h11223344, 32'h00000000, 1'b0, 3, 1, 1, 32'h11AB3344));
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 8'h10, 32'h9999CAFE, 1'b0, 32'h0,        32'h00000000, 1'b0, 3, 1, 1, 32'h11ABCAFE));
        vecs.push_back(mk(1'b1, 2'b01, 1'b1, 8'h12, 32'hAAAA5555, 1'b0, 32'h0,        32'h00000000, 1'b0, 3, 1, 1, 32'h5555CAFE));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 8'h13, 32'hFFFFFF7E, 1'b0, 32'h0,        32'h00000000, 1'b0, 3, 1, 1, 32'h7E55CAFE));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 8'h21, 32'h0,        1'b1, 32'h80F07F01, 32'h0000007F, 1'b0, 3, 1, 0, 32'h80F07F01));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 8'h22, 32'h0,        1'b0, 32'h0,        32'hFFFFFFF0, 1'b0, 3, 1, 0, 32'h80F07F01));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 8'h22, 32'h0,        1'b0, 32'h0,        32'h000000F0, 1'b0, 3, 1, 0, 32'h80F07F01));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 8'h22, 32'h0,        1'b0, 32'h0,        32'hFFFF80F0, 1'b0, 3, 1, 0, 32'h80F07F01));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 8'h22, 32'h0,        1'b0, 32'h0,        32'h000080F0, 1'b0, 3, 1, 0, 32'h80F07F01));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 8'h21, 32'h0,        1'b0, 32'h0,        32'h0000007F, 1'b0, 3, 1, 0, 32'h80F07F01));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 8'h23, 32'h0,        1'b0, 32'h0,        32'hFFFFFF80, 1'b0, 3, 1, 0, 32'h80F07F01));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 8'h20, 32'h0,        1'b0, 32'h0,        32'h00007F01, 1'b0, 3, 1, 0, 32'h80F07F01));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 8'h13, 32'h0,        1'b0, 32'h0,        32'h00000000, 1'b1, 1, 0, 0, 32'h7E55CAFE));
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 8'h11, 32'h0000BEEF, 1'b0, 32'h0,        32'h00000000, 1'b1, 1, 0, 0, 32'h7E55CAFE));
        vecs.push_back(mk(1'b1, 2'b11, 1'b0, 8'h00, 32'h12345678, 1'b1, 32'h0BADF00D, 32'h00000000, 1'b1, 1, 0, 0, 32'h0BADF00D));

        // Reset state.
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("rst_resp_valid", 32'(bus.RespValid), 32'd0);
        check("rst_resp_data", bus.RespData, 32'd0);
        check("rst_mis_err", 32'(bus.MisalignedError), 32'd0);
        check("rst_mem_addr", 32'(bus.MemAddress), 32'd0);
        check("rst_mem_wdata", bus.MemWriteData, 32'd0);
        check("rst_mem_read", 32'(bus.MemRead), 32'd0);
        check("rst_mem_write", 32'(bus.MemWrite), 32'd0);
        check("rst_ready_low", 32'(bus.ReqReady), 32'd0);
        Reset = 1'b0;
        run   = 1'b1;
        #1;
        check("rst_ready_high", 32'(bus.ReqReady), 32'd1);

        for (int i = 0; i < vecs.size(); i++) do_req(vecs[i], i);

        // Reset during RMW_MERGE: no write, no response, word preserved.
        @(negedge Clock);
        mem[4] = 32'h11223344;
        w0 = wr_cnt;
        bus.ReqValid = 1'b1; bus.ReqWrite = 1'b1; bus.ReqSize = 2'b00;
        bus.ReqSigned = 1'b0; bus.ReqAddress = 8'h12; bus.ReqWriteData = 32'h000000AB;
        @(posedge Clock);
        @(negedge Clock);
        bus.ReqValid = 1'b0;
        check("rstmid_rmw_read", 32'(bus.MemRead), 32'd1);
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        check("rstmid_ready_low", 32'(bus.ReqReady), 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("rstmid_ready_after", 32'(bus.ReqReady), 32'd1);
        repeat (3) @(negedge Clock);
        check("rstmid_no_write", 32'(wr_cnt - w0), 32'd0);
        check("rstmid_mem", mem[4], 32'h11223344);

        // ReqValid held across lw then back-to-back sw.
        @(negedge Clock);
        r0 = rd_cnt;
        w0 = wr_cnt;
        bus.ReqValid = 1'b1; bus.ReqWrite = 1'b0; bus.ReqSize = 2'b10;
        bus.ReqSigned = 1'b0; bus.ReqAddress = 8'h20; bus.ReqWriteData = 32'h0;
        sb_q.push_back('{32'h80F07F01, 1'b0});
        cyc = 0; got = 0; stall_ok = 1;
        while (!got && cyc < 10) begin
            @(negedge Clock);
            cyc++;
            if (bus.RespValid === 1'b1) got = 1;
            else stall_ok &= (bus.Stall === 1'b1);
        end
        check("held_lw_seen", 32'(got), 32'd1);
        check("held_lw_latency", 32'(cyc), 32'd3);
        check("held_lw_stall", 32'(stall_ok), 32'd1);
        check("held_lw_stall_drop", 32'(bus.Stall), 32'd0);
        bus.ReqWrite = 1'b1; bus.ReqAddress = 8'h24; bus.ReqWriteData = 32'h12345678;
        sb_q.push_back('{32'h00000000, 1'b0});
        cyc = 0; got = 0; stall_ok = 1;
        while (!got && cyc < 10) begin
            @(negedge Clock);
            cyc++;
            if (bus.RespValid === 1'b1) got = 1;
            else stall_ok &= (bus.Stall === 1'b1);
        end
        bus.ReqValid = 1'b0;
        check("held_sw_seen", 32'(got), 32'd1);
        check("held_sw_latency", 32'(cyc), 32'd2);
        check("held_sw_stall", 32'(stall_ok), 32'd1);
        repeat (3) @(negedge Clock);
        check("held_reads", 32'(rd_cnt - r0), 32'd1);
        check("held_writes", 32'(wr_cnt - w0), 32'd1);
        check("held_mem", mem[9], 32'h12345678);
        check("held_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_memory_access_unit.md
Name: data_memory_access_unit

Overview:
- MEM-stage initiator for the word-organised data memory: accepts load/store requests from the pipeline and drives the memory's Address/WriteData/MemoryRead/MemoryWrite pins.
- Captures the memory's registered ReadData and returns formatted load data.
- Adds byte/halfword loads (signed/unsigned) and byte/halfword stores via read-modify-write, plus alignment checking and a pipeline stall output.

Parameters:
DATA_WIDTH, 32, data word width; only 32 is supported.
ADDRESS_WIDTH, 6, memory word-address width; byte address is ADDRESS_WIDTH+2 bits.

Ports:
Clock  input  1  single clock; all state updates on posedge.
Reset  input  1  synchronous, active-high reset.
ReqValid  input  1  pipeline presents a memory request.
ReqReady  output  1  unit idle, can accept a request; equals (state==IDLE && !Reset).
ReqWrite  input  1  1=store, 0=load.
ReqSize  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
ReqSigned  input  1  loads: 1 sign-extend, 0 zero-extend; ignored for stores and words.
ReqAddress  input  ADDRESS_WIDTH+2  byte address.
ReqWriteData  input  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
RespValid  output  1  one-cycle pulse: request complete.
RespData  output  DATA_WIDTH  formatted load data, valid with RespValid on loads; 0 otherwise.
MisalignedError  output  1  with RespValid: request rejected, no memory access.
Stall  output  1  ReqValid && !RespValid; holds the pipeline MEM stage.
MemAddress  output  ADDRESS_WIDTH  word address = ReqAddress[ADDRESS_WIDTH+1:2], registered.
MemWriteData  output  DATA_WIDTH  word to write, registered.
MemRead  output  1  read strobe, registered; memory returns data on MemReadData one cycle later.
MemWrite  output  1  write strobe, registered; memory commits at the negedge of the same cycle.
MemReadData  input  DATA_WIDTH  memory read data.

Behaviour:
- Reset (sync, sampled at posedge): state=IDLE; RespValid, RespData, MisalignedError, MemAddress, MemWriteData, MemRead, MemWrite all 0. ReqReady=0 while Reset is high.
- Accept rule: accept only when ReqValid && ReqReady at posedge E0. Request fields are latched at E0. ReqReady=0 in every non-IDLE state, so a held ReqValid is never double-accepted.
- Alignment:
  - Half requires addr[0]==0; word requires addr[1:0]==0.
  - Size 11 is always misaligned.
  - Misaligned → state ERR for cycle 1: RespValid=1, MisalignedError=1, MemRead=MemWrite=0 throughout; back to IDLE.
- Lanes: little-endian; byte offset k=addr[1:0] occupies bits [8k+7:8k]. Half at offset 0 uses [15:0]; offset 2 uses [31:16].
- Word store: cycle 1 state WRITE: MemWrite=1, MemWriteData=ReqWriteData, RespValid=1. Back to IDLE. Latency 1.
- Load:
  - Cycle 1 READ: MemRead=1.
  - Cycle 2 CAPTURE: extract lane from MemReadData, sign/zero-extend, register into RespData at E2.
  - Cycle 3 RESP: RespValid=1.
  - Latency 3. RespData returns to 0 after RESP.
- Sub-word store (read-modify-write):
  - Cycle 1 RMW_READ: MemRead=1.
  - Cycle 2 RMW_MERGE: merge ReqWriteData low byte/half into the addressed lane of MemReadData; register into MemWriteData; MemWrite=1 launched at E2.
  - Cycle 3 RMW_WRITE: MemWrite=1, RespValid=1.
  - Other lanes are preserved bit-exact. Latency 3.
- MemRead and MemWrite are never high in the same cycle. Each is high for exactly one cycle per access.
- MemAddress is held constant from cycle 1 until return to IDLE.
- Reset mid-operation: the state machine aborts to IDLE and no RespValid is issued.
  - A write already launched (MemWrite=1 in the current cycle) still commits at that cycle's negedge.
  - Reset sampled during RMW_READ or RMW_MERGE prevents any write.
- States: IDLE, ERR, WRITE, READ, CAPTURE, RESP, RMW_READ, RMW_MERGE, RMW_WRITE. All non-IDLE states are single-cycle and advance unconditionally.

Test Plan:
- sw 0xDEADBEEF @0x10, then lw @0x10 → MemAddress=4, MemWrite high 1 cycle; load RespData=0xDEADBEEF, RespValid 3 cycles after accept.
- Word 4 preset 0x11223344; sb 0xAB @0x12 → MemRead 1 cycle, then MemWrite 1 cycle, word=0x11AB3344; sh 0xCAFE @0x10 → 0x11ABCAFE.
- Word 8 = 0x80F07F01: lbu @0x21→0x0000007F; lb @0x22→0xFFFFFFF0; lbu @0x22→0x000000F0; lh @0x22→0xFFFF80F0; lhu @0x22→0x000080F0.
- lw @0x13, sh @0x11, size=11 @0x00 → each gives RespValid+MisalignedError in cycle 1; MemRead/MemWrite stay 0; memory unchanged.
- sb to 0x12 with Reset asserted in RMW_MERGE → no MemWrite, no RespValid, word unchanged, ReqReady=1 the cycle after Reset drops.
- ReqValid held high across lw then back-to-back sw → Stall high until each RespValid cycle; exactly one MemRead and one MemWrite; no duplicate accept.
